// File: rtl/seven_segment_reader.sv
// seven_segment_reader: decodes multiplexed active-low 7-segment scan lines back to hex digits, DP and frame pulses.
// Define SEVEN_SEGMENT_READER_SYNC_EN to pass anodes/segments through a two-flop synchroniser first.
module seven_segment_reader #(
    parameter int DIGITS        = 8,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DIGITS-1:0]     anodes,
    input  logic [7:0]            segments,
    output logic [4*DIGITS-1:0]   digit_values,
    output logic [DIGITS-1:0]     digit_valid,
    output logic [DIGITS-1:0]     digit_dp,
    output logic                  frame_valid,
    output logic                  decode_error
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int IW = $clog2(DIGITS);
    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HOLD} state_t;
    logic [DIGITS+7:0] raw, smp;
    logic [DIGITS-1:0] an_s, mask, mask_n;
    logic [7:0]        seg_s, cand_seg, cand_seg_n;
    logic [IW-1:0]     idx, cand_idx, cand_idx_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [4:0]        dec;
    logic              onehot, same, capture;
    state_t            state, state_n;
`ifdef SEVEN_SEGMENT_READER_SYNC_EN
    logic [DIGITS+7:0] sync1, sync2;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {anodes, segments};
            sync2 <= sync1;
        end
    end
    assign raw = sync2;
`else
    assign raw = {anodes, segments};
`endif
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) smp <= '1;
        else          smp <= raw;
    end
    assign an_s   = smp[DIGITS+7:8];
    assign seg_s  = smp[7:0];
    assign onehot = $onehot(~an_s);
    always_comb begin
        idx = '0;
        for (int i = 0; i < DIGITS; i++)
            if (!an_s[i]) idx = IW'(i);
    end
    assign same = onehot && idx == cand_idx && seg_s == cand_seg;
    always_comb begin
        state_n    = state;
        cand_idx_n = cand_idx;
        cand_seg_n = cand_seg;
        cnt_n      = cnt;
        capture    = 1'b0;
        case (state)
            S_WAIT: if (onehot) begin
                cand_idx_n = idx;
                cand_seg_n = seg_s;
                cnt_n      = CW'(1);
                state_n    = S_SETTLE;
            end
            S_SETTLE: if (!onehot) state_n = S_WAIT;
            else if (!same) begin
                cand_idx_n = idx;
                cand_seg_n = seg_s;
                cnt_n      = CW'(1);
            end else begin
                cnt_n = cnt + CW'(1);
                if (cnt_n == CW'(SETTLE_CYCLES)) begin
                    capture = 1'b1;
                    state_n = S_HOLD;
                end
            end
            S_HOLD: if (!onehot) state_n = S_WAIT;
            else if (!same) begin
                cand_idx_n = idx;
                cand_seg_n = seg_s;
                cnt_n      = CW'(1);
                state_n    = S_SETTLE;
            end
            default: state_n = S_WAIT;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_WAIT;
            cand_idx <= '0;
            cand_seg <= '1;
            cnt      <= '0;
        end else begin
            state    <= state_n;
            cand_idx <= cand_idx_n;
            cand_seg <= cand_seg_n;
            cnt      <= cnt_n;
        end
    end
    // segments are active-low with DP in bit 0; decode works on active-high A..G
    always_comb begin
        case (~cand_seg[7:1])
            7'b1111110: dec = 5'h10;
            7'b0110000: dec = 5'h11;
            7'b1101101: dec = 5'h12;
            7'b1111001: dec = 5'h13;
            7'b0110011: dec = 5'h14;
            7'b1011011: dec = 5'h15;
            7'b1011111: dec = 5'h16;
            7'b1110000: dec = 5'h17;
            7'b1111111: dec = 5'h18;
            7'b1111011: dec = 5'h19;
            7'b1110111: dec = 5'h1a;
            7'b0011111: dec = 5'h1b;
            7'b0001101: dec = 5'h1c;
            7'b0111101: dec = 5'h1d;
            7'b1001111: dec = 5'h1e;
            7'b1000111: dec = 5'h1f;
            default:    dec = 5'h00;
        endcase
    end
    always_comb begin
        mask_n = mask;
        for (int i = 0; i < DIGITS; i++)
            if (cand_idx == IW'(i)) mask_n[i] = 1'b1;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_values <= '0;
            digit_valid  <= '0;
            digit_dp     <= '0;
            frame_valid  <= 1'b0;
            decode_error <= 1'b0;
            mask         <= '0;
        end else begin
            frame_valid  <= capture && &mask_n;
            decode_error <= capture && !dec[4];
            if (capture) begin
                mask <= &mask_n ? '0 : mask_n;
                for (int i = 0; i < DIGITS; i++)
                    if (cand_idx == IW'(i)) begin
                        digit_values[4*i +: 4] <= dec[3:0];
                        digit_valid[i]         <= dec[4];
                        digit_dp[i]            <= ~cand_seg[0];
                    end
            end
        end
    end
endmodule

// File: tb/tb_seven_segment_reader.sv
// tb_seven_segment_reader: directed scans; expected output events are queued by the stimulus and
// checked by an independent monitor against every observed output change or pulse.
module tb_seven_segment_reader;
`ifdef SEVEN_SEGMENT_READER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int S = 4;
    localparam logic [6:0] GL [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                       7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                       7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                       7'b0001101, 7'b0111101, 7'b1001111, 7'b1000111};
    typedef struct {
        logic [23:0] o;
        logic        fv;
        logic        de;
        int          cyc;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  anodes = 4'hf;
    logic [7:0]  segments = 8'hff;
    logic [15:0] digit_values;
    logic [3:0]  digit_valid, digit_dp;
    logic        frame_valid, decode_error;
    logic        mon_en = 1'b0;
    logic [23:0] last = '0;
    int          cyc = 0, compared = 0, failed = 0;
    exp_t        sbq[$];
    seven_segment_reader #(.DIGITS(4), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset_n(reset_n), .anodes(anodes), .segments(segments),
        .digit_values(digit_values), .digit_valid(digit_valid), .digit_dp(digit_dp),
        .frame_valid(frame_valid), .decode_error(decode_error)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [7:0] sg(input int v, input logic dp);
        return ~{GL[v], dp};
    endfunction
    task automatic step(input logic [3:0] an, input logic [7:0] seg, input int n);
        anodes = an;
        segments = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic expect_ev(input logic [15:0] v, input logic [3:0] ok, input logic [3:0] dp,
                             input logic fv, input logic de, input int c);
        exp_t e;
        e.o = {v, ok, dp};
        e.fv = fv;
        e.de = de;
        e.cyc = c;
        sbq.push_back(e);
    endtask
    always @(negedge clk) if (mon_en) begin
        logic [23:0] snap;
        exp_t e;
        snap = {digit_values, digit_valid, digit_dp};
        if (snap !== last || frame_valid || decode_error) begin
            compared++;
            if (sbq.size() == 0) begin
                failed++;
                $display("FAIL unexpected_event cyc=%0d got vals=%h valid=%b dp=%b fv=%b de=%b, required no event",
                         cyc, digit_values, digit_valid, digit_dp, frame_valid, decode_error);
            end else begin
                e = sbq.pop_front();
                if ({snap, frame_valid, decode_error} !== {e.o, e.fv, e.de} || cyc != e.cyc) begin
                    failed++;
                    $display("FAIL event cyc=%0d vals=%h valid=%b dp=%b fv=%b de=%b, required cyc=%0d vals=%h valid=%b dp=%b fv=%b de=%b",
                             cyc, digit_values, digit_valid, digit_dp, frame_valid, decode_error,
                             e.cyc, e.o[23:8], e.o[7:4], e.o[3:0], e.fv, e.de);
                end
            end
        end
        last = snap;
    end
    initial begin
        int k;
        step(4'b1110, sg(2, 1'b0), 3);
        compared++;
        if ({digit_values, digit_valid, digit_dp, frame_valid, decode_error} !== 26'd0) begin
            failed++;
            $display("FAIL reset_state got vals=%h valid=%b dp=%b fv=%b de=%b, required all zero",
                     digit_values, digit_valid, digit_dp, frame_valid, decode_error);
        end
        mon_en = 1'b1;
        // reset release with a 2 already on digit 0
        k = cyc;
        expect_ev(16'h0002, 4'b0001, 4'b0000, 0, 0, k + 1 + S + LAT);
        reset_n = 1'b1;
        step(4'b1110, sg(2, 1'b0), 12);
        // glitch on digit 1 restarts the count from the restore
        step(4'b1101, sg(7, 1'b0), 3);
        step(4'b1101, sg(1, 1'b0), 1);
        k = cyc;
        expect_ev(16'h0072, 4'b0011, 4'b0000, 0, 0, k + 1 + S + LAT);
        step(4'b1101, sg(7, 1'b0), 10);
        // full frame A b c. d
        k = cyc;
        expect_ev(16'h007a, 4'b0011, 4'b0000, 0, 0, k + 1 + S + LAT);
        step(4'b1110, sg(10, 1'b0), 10);
        k = cyc;
        expect_ev(16'h00ba, 4'b0011, 4'b0000, 0, 0, k + 1 + S + LAT);
        step(4'b1101, sg(11, 1'b0), 10);
        k = cyc;
        expect_ev(16'h0cba, 4'b0111, 4'b0100, 0, 0, k + 1 + S + LAT);
        step(4'b1011, sg(12, 1'b1), 10);
        k = cyc;
        expect_ev(16'hdcba, 4'b1111, 4'b0100, 1, 0, k + 1 + S + LAT);
        step(4'b0111, sg(13, 1'b0), 10);
        // dash is illegal; ghosting never captures
        k = cyc;
        expect_ev(16'hd0ba, 4'b1011, 4'b0000, 0, 1, k + 1 + S + LAT);
        step(4'b1011, ~8'b00000010, 10);
        step(4'b1100, sg(8, 1'b0), 12);
        // mid-frame reset
        k = cyc;
        expect_ev(16'hd0b0, 4'b1011, 4'b0000, 0, 0, k + 1 + S + LAT);
        step(4'b1110, sg(0, 1'b0), 10);
        k = cyc;
        expect_ev(16'hd010, 4'b1011, 4'b0000, 0, 0, k + 1 + S + LAT);
        step(4'b1101, sg(1, 1'b0), 10);
        k = cyc;
        expect_ev(16'h0000, 4'b0000, 4'b0000, 0, 0, k);
        reset_n = 1'b0;
        step(4'b1111, 8'hff, 2);
        reset_n = 1'b1;
        // reverse order so a stale mask would fire frame_valid early
        k = cyc;
        expect_ev(16'h8000, 4'b1000, 4'b0000, 0, 0, k + 1 + S + LAT);
        step(4'b0111, sg(8, 1'b0), 10);
        k = cyc;
        expect_ev(16'h8600, 4'b1100, 4'b0000, 0, 0, k + 1 + S + LAT);
        step(4'b1011, sg(6, 1'b0), 10);
        k = cyc;
        expect_ev(16'h8650, 4'b1110, 4'b0000, 0, 0, k + 1 + S + LAT);
        step(4'b1101, sg(5, 1'b0), 10);
        k = cyc;
        expect_ev(16'h8654, 4'b1111, 4'b0000, 1, 0, k + 1 + S + LAT);
        step(4'b1110, sg(4, 1'b0), 10);
        step(4'b1111, 8'hff, 5);
        compared++;
        if (sbq.size() != 0) begin
            failed++;
            $display("FAIL missing_events got %0d still pending, required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule

// File: doc/seven_segment_reader.md
# seven_segment_reader

Scan-side reader for multiplexed seven-segment displays: samples active-low anode and cathode lines, waits for each digit's pattern to settle, and decodes it back to a 4-bit hex value plus decimal point. It sits beside a display driver or on external display pins. It provides self-checking readback of what the driver actually shows, and per-frame snapshots for logging.

## Interface
- DIGITS, 8, number of multiplexed digits, 2..8
- SETTLE_CYCLES, 16, consecutive identical samples required before capture, 2..255
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- anodes  input  DIGITS  digit enables, active-low, bit i = digit i
- segments  input  8  cathodes, active-low, bit7..bit0 = CA,CB,CC,CD,CE,CF,CG,DP
- digit_values  output  4*DIGITS  decoded value, digit i at [4i+3:4i]
- digit_valid  output  DIGITS  1 = last capture of digit i was a legal glyph
- digit_dp  output  DIGITS  decimal point of last capture of digit i
- frame_valid  output  1  one-cycle pulse: every digit captured since last pulse
- decode_error  output  1  one-cycle pulse: captured pattern not a legal glyph

## Operation
- The sample is {anodes, segments} after optional synchronisation. A sample is *one-hot* when exactly one anode bit is 0.
- Settle FSM states:
  - WAIT
  - SETTLE, with candidate index, candidate pattern and counter
  - HOLD
- WAIT: on a one-hot sample, load candidate = (index, segments) and counter = 1, then go to SETTLE. Otherwise stay in WAIT.
- SETTLE, on each edge:
  - Sample not one-hot: go to WAIT.
  - Sample one-hot but index or segments differ from the candidate: reload the candidate, set counter = 1, and stay in SETTLE.
  - Sample identical to the candidate: increment counter. When the counter reaches SETTLE_CYCLES, capture and go to HOLD.
- HOLD: while the sample is identical, stay and do not capture again. On a different one-hot sample, reload and go to SETTLE. On a non-one-hot sample, go to WAIT.
- Capture of digit i writes slot i only:
  - digit_dp[i] = ~segments[0].
  - Legal glyph: digit_values[i] = decoded value, digit_valid[i] = 1.
  - Illegal glyph: digit_values[i] = 0, digit_valid[i] = 0, decode_error pulses.
- Legal glyphs use active-high segments A..G, ignoring DP: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, c=0001101, d=0111101, E=1001111, F=1000111. Every other pattern is illegal, including blank and dash (0000001).
- Frame tracking:
  - A seen mask of DIGITS bits is set by every capture, legal or not.
  - The capture that makes the mask all ones sets frame_valid high for the next cycle and clears the mask in that same cycle.
  - Recapturing an already-seen digit does not affect the mask.
- Anode bits outside DIGITS do not exist. Multiple low anodes count as not one-hot, which covers ghosting and overlap.

## Timing
- Reset values: digit_values 0, digit_valid 0, digit_dp 0, frame_valid 0, decode_error 0, FSM in WAIT, mask 0, counter 0.
- Reset mid-SETTLE or mid-frame discards the candidate and mask immediately.
- Capture latency: slot registers update on the edge that takes the SETTLE_CYCLES-th identical sample. This is SETTLE_CYCLES edges after the first sample is registered; add 2 edges with the synchroniser.
- decode_error is asserted in the cycle after the capture edge and lasts exactly one cycle.
- frame_valid is asserted in the cycle after the capture edge and lasts exactly one cycle.
- Each pulse is at most 1 cycle wide. Back-to-back pulses are impossible because SETTLE_CYCLES ≥ 2.
- Counter width is ceil(log2(SETTLE_CYCLES+1)). It saturates and cannot wrap, because HOLD stops counting.
- A glitch of one cycle in SETTLE restarts the count, so no partial credit is kept.

## Configuration
- SEVEN_SEGMENT_READER_SYNC_EN:
  - Defined: anodes and segments each pass through a two-flop synchroniser reset to all ones (inactive), adding 2 cycles of latency.
  - Undefined: the sample is the inputs registered once, for on-chip use with a synchronous driver.

## Test plan
All scenarios use DIGITS=4 and SETTLE_CYCLES=4, with the sync macro off unless stated.
- Reset: drive anodes=4'b1110, segments=~8'b11011010 while reset_n=0 → all outputs 0, no capture. Release reset and hold 4 cycles → digit_values[3:0]=2, digit_valid=4'b0001, digit_dp=0.
- Glitch restart: hold a 7 on digit 1 for 3 cycles, change segments for 1 cycle, then restore → capture of 7 occurs only 4 cycles after the restore.
- Full frame: scan digits 0..3 showing A, b, c with DP, and d, 10 cycles each → digit_values=16'hDCBA, digit_dp=4'b0100. frame_valid pulses once, 1 cycle after digit 3's capture.
- Illegal glyphs: a dash on digit 2 → decode_error pulse, digit_valid[2]=0, digit_values[11:8]=0. A ghost scan with anodes=4'b1100 → FSM in WAIT, no capture.
- Mid-frame reset: capture digits 0 and 1, then assert reset_n=0 → outputs clear. Next full scan → frame_valid pulses only after all 4 digits are captured again.
- Macro on: repeat the reset scenario → capture 2 cycles later than without the macro.
